// File: rtl/rtc_time_ctrl_if.sv
// Software time-set handshake: level request with load values, one-cycle ack back.
interface rtc_time_ctrl_if;
    logic       i_sw_req;
    logic [7:0] i_sw_sec;
    logic [7:0] i_sw_min;
    logic [7:0] i_sw_hour;
    logic       o_sw_ack;

    modport master (
        output i_sw_req,
        output i_sw_sec,
        output i_sw_min,
        output i_sw_hour,
        input  o_sw_ack
    );

    modport slave (
        input  i_sw_req,
        input  i_sw_sec,
        input  i_sw_min,
        input  i_sw_hour,
        output o_sw_ack
    );
endinterface

// File: rtl/rtc_time_ctrl.sv
// RTC time-of-day controller: prescaled tenth-second counting, software load
// handshake, front-panel adjust buttons and hour:minute alarm.
module rtc_time_ctrl #(
    parameter int unsigned TICK_DIV = 10_000_000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_run,
    rtc_time_ctrl_if.slave     sw,
    input  logic               i_adj_min,
    input  logic               i_adj_hour,
    input  logic               i_alarm_en,
    input  logic [7:0]         i_alarm_min,
    input  logic [7:0]         i_alarm_hour,
    output logic [7:0]         o_msec,
    output logic [7:0]         o_sec,
    output logic [7:0]         o_min,
    output logic [7:0]         o_hour,
    output logic               o_tick,
    output logic               o_alarm,
    output logic               o_busy
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LOAD     = 2'd1,
        ST_WAIT_REL = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    msec_q, msec_d;
    logic [7:0]    sec_q, sec_d;
    logic [7:0]    min_q, min_d;
    logic [7:0]    hour_q, hour_d;
    logic          tick_q, tick_d;
    logic          alarm_q, alarm_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;

    logic [7:0]    inc_msec, inc_sec, inc_min, inc_hour;
    logic [7:0]    sat_sec, sat_min, sat_hour;
    logic          alarm_hit;
    logic          count_en;

    // Full carry chain for one tenth-of-second increment
    always_comb begin
        inc_msec = msec_q;
        inc_sec  = sec_q;
        inc_min  = min_q;
        inc_hour = hour_q;
        if (msec_q == 8'd9) begin
            inc_msec = 8'd0;
            if (sec_q == 8'd59) begin
                inc_sec = 8'd0;
                if (min_q == 8'd59) begin
                    inc_min  = 8'd0;
                    inc_hour = (hour_q == 8'd23) ? 8'd0 : hour_q + 8'd1;
                end else begin
                    inc_min = min_q + 8'd1;
                end
            end else begin
                inc_sec = sec_q + 8'd1;
            end
        end else begin
            inc_msec = msec_q + 8'd1;
        end
    end

    // Out-of-range load values clamp to the field maximum
    always_comb begin
        sat_sec  = (sw.i_sw_sec  > 8'd59) ? 8'd59 : sw.i_sw_sec;
        sat_min  = (sw.i_sw_min  > 8'd59) ? 8'd59 : sw.i_sw_min;
        sat_hour = (sw.i_sw_hour > 8'd23) ? 8'd23 : sw.i_sw_hour;
    end

    // Alarm only evaluated against the post-increment time; range errors never match
    always_comb begin
        alarm_hit = i_alarm_en
                 && (inc_hour == i_alarm_hour)
                 && (inc_min  == i_alarm_min)
                 && (inc_sec  == 8'd0)
                 && (inc_msec == 8'd0);
    end

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        msec_d   = msec_q;
        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        tick_d   = 1'b0;
        alarm_d  = 1'b0;
        ack_d    = 1'b0;
        count_en = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (sw.i_sw_req) begin
                    state_d  = ST_LOAD;
                    count_en = i_run;
                end else if (i_adj_min || i_adj_hour) begin
                    // Buttons override a coincident tick and restart the second
                    if (i_adj_min) begin
                        min_d = (min_q == 8'd59) ? 8'd0 : min_q + 8'd1;
                    end
                    if (i_adj_hour) begin
                        hour_d = (hour_q == 8'd23) ? 8'd0 : hour_q + 8'd1;
                    end
                    sec_d   = 8'd0;
                    msec_d  = 8'd0;
                    presc_d = '0;
                end else begin
                    count_en = i_run;
                end
            end
            ST_LOAD: begin
                sec_d   = sat_sec;
                min_d   = sat_min;
                hour_d  = sat_hour;
                msec_d  = 8'd0;
                presc_d = '0;
                ack_d   = 1'b1;
                state_d = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (!sw.i_sw_req) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (count_en) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                msec_d  = inc_msec;
                sec_d   = inc_sec;
                min_d   = inc_min;
                hour_d  = inc_hour;
                tick_d  = 1'b1;
                alarm_d = alarm_hit;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        busy_d = (state_d != ST_RUN);
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_RUN;
            presc_q <= '0;
            msec_q  <= 8'd0;
            sec_q   <= 8'd0;
            min_q   <= 8'd0;
            hour_q  <= 8'd0;
            tick_q  <= 1'b0;
            alarm_q <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            msec_q  <= msec_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            tick_q  <= tick_d;
            alarm_q <= alarm_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign o_msec      = msec_q;
    assign o_sec       = sec_q;
    assign o_min       = min_q;
    assign o_hour      = hour_q;
    assign o_tick      = tick_q;
    assign o_alarm     = alarm_q;
    assign o_busy      = busy_q;
    assign sw.o_sw_ack = ack_q;

endmodule

// File: tb/tb_rtc_time_ctrl.sv
// Self-checking bench for rtc_time_ctrl: directed sequences and table vectors,
// then random stimulus, all cross-checked against a tenths-of-day reference model.
module tb_rtc_time_ctrl;

    localparam int DIV = 4;
    localparam int DAY = 864000;

    logic       clk = 1'b0;
    logic       rst, run, adjm, adjh, aen;
    logic [7:0] amin, ahour;
    logic [7:0] msec, sec, min, hour;
    logic       tick, alarm, busy;

    rtc_time_ctrl_if sw_if ();

    rtc_time_ctrl #(.TICK_DIV(DIV)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_run       (run),
        .sw          (sw_if.slave),
        .i_adj_min   (adjm),
        .i_adj_hour  (adjh),
        .i_alarm_en  (aen),
        .i_alarm_min (amin),
        .i_alarm_hour(ahour),
        .o_msec      (msec),
        .o_sec       (sec),
        .o_min       (min),
        .o_hour      (hour),
        .o_tick      (tick),
        .o_alarm     (alarm),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: time of day as a count of tenths since midnight
    int m_t, m_pre, m_ph;
    bit m_tick, m_alarm, m_ack;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic advance();
        if (!run) return;
        if (m_pre == DIV - 1) begin
            m_pre   = 0;
            m_t     = (m_t + 1) % DAY;
            m_tick  = 1;
            m_alarm = aen && (m_t % 600 == 0) && (m_t / 36000 == int'(ahour))
                      && ((m_t / 600) % 60 == int'(amin));
        end else begin
            m_pre++;
        end
    endtask

    task automatic model_step();
        int h, m;
        m_tick = 0; m_alarm = 0; m_ack = 0;
        if (rst) begin
            m_t = 0; m_pre = 0; m_ph = 0;
        end else if (m_ph == 0) begin
            if (sw_if.i_sw_req) begin
                advance();
                m_ph = 1;
            end else if (adjm || adjh) begin
                h = m_t / 36000;
                m = (m_t / 600) % 60;
                if (adjm) m = (m + 1) % 60;
                if (adjh) h = (h + 1) % 24;
                m_t = h * 36000 + m * 600;
                m_pre = 0;
            end else begin
                advance();
            end
        end else if (m_ph == 1) begin
            m_t = sat(int'(sw_if.i_sw_hour), 23) * 36000 + sat(int'(sw_if.i_sw_min), 59) * 600
                + sat(int'(sw_if.i_sw_sec), 59) * 10;
            m_pre = 0;
            m_ack = 1;
            m_ph  = 2;
        end else begin
            if (!sw_if.i_sw_req) m_ph = 0;
        end
    endtask

    // One clock: predict, clock, compare every output against the model
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("m_msec",  msec,  m_t % 10);
        chk("m_sec",   sec,   (m_t / 10) % 60);
        chk("m_min",   min,   (m_t / 600) % 60);
        chk("m_hour",  hour,  m_t / 36000);
        chk("m_tick",  tick,  int'(m_tick));
        chk("m_alarm", alarm, int'(m_alarm));
        chk("m_ack",   sw_if.o_sw_ack, int'(m_ack));
        chk("m_busy",  busy,  int'(m_ph != 0));
    endtask

    task automatic set_sw(input int h, input int m, input int s);
        sw_if.i_sw_hour = 8'(h);
        sw_if.i_sw_min  = 8'(m);
        sw_if.i_sw_sec  = 8'(s);
    endtask

    task automatic load_release(input int h, input int m, input int s);
        set_sw(h, m, s);
        sw_if.i_sw_req = 1'b1;
        cyc();
        cyc();
        sw_if.i_sw_req = 1'b0;
        cyc();
    endtask

    task automatic chk_time(input string name, input int h, input int m, input int s, input int ms);
        chk(name, {hour, min, sec, msec}, (h << 24) | (m << 16) | (s << 8) | ms);
    endtask

    typedef struct {
        int s, m, h;
        int es, em, eh;
    } ld_vec_t;

    ld_vec_t tbl[6];
    int ticks, maxms, nal;

    initial begin
        tbl[0] = '{s: 75,  m: 10,  h: 30,  es: 59, em: 10, eh: 23};
        tbl[1] = '{s: 0,   m: 60,  h: 0,   es: 0,  em: 59, eh: 0};
        tbl[2] = '{s: 59,  m: 59,  h: 23,  es: 59, em: 59, eh: 23};
        tbl[3] = '{s: 255, m: 255, h: 255, es: 59, em: 59, eh: 23};
        tbl[4] = '{s: 12,  m: 34,  h: 5,   es: 12, em: 34, eh: 5};
        tbl[5] = '{s: 60,  m: 0,   h: 24,  es: 59, em: 0,  eh: 23};

        rst = 1'b1; run = 1'b0; adjm = 1'b0; adjh = 1'b0;
        aen = 1'b0; amin = 8'd0; ahour = 8'd0;
        sw_if.i_sw_req = 1'b0;
        set_sw(0, 0, 0);
        m_t = 0; m_pre = 0; m_ph = 0;

        // Reset state
        cyc();
        chk_time("rst_time", 0, 0, 0, 0);
        chk("rst_flags", {tick, alarm, sw_if.o_sw_ack, busy}, 0);
        rst = 1'b0;
        run = 1'b1;

        // Free-run 40 cycles: ten ticks, msec reaches 9 then wraps into sec
        ticks = 0; maxms = 0;
        repeat (40) begin
            cyc();
            if (tick) ticks++;
            if (int'(msec) > maxms) maxms = int'(msec);
        end
        chk("run40_ticks", ticks, 10);
        chk("run40_maxms", maxms, 9);
        chk_time("run40_time", 0, 0, 1, 0);

        // Load 23:59:59, ack timing, busy until release, then midnight rollover
        set_sw(23, 59, 59);
        sw_if.i_sw_req = 1'b1;
        cyc();
        chk("ld_ack_n1", sw_if.o_sw_ack, 0);
        chk("ld_busy_n1", busy, 1);
        cyc();
        chk("ld_ack_n2", sw_if.o_sw_ack, 1);
        chk_time("ld_time", 23, 59, 59, 0);
        cyc();
        chk("ld_ack_n3", sw_if.o_sw_ack, 0);
        chk("ld_busy_hold", busy, 1);
        sw_if.i_sw_req = 1'b0;
        cyc();
        chk("ld_busy_rel", busy, 0);
        repeat (40) cyc();
        chk_time("rollover", 0, 0, 0, 0);

        // Saturating load table
        foreach (tbl[i]) begin
            set_sw(tbl[i].h, tbl[i].m, tbl[i].s);
            sw_if.i_sw_req = 1'b1;
            cyc();
            cyc();
            chk_time("sat_load", tbl[i].eh, tbl[i].em, tbl[i].es, 0);
            sw_if.i_sw_req = 1'b0;
            cyc();
        end

        // Reset while waiting for release
        set_sw(12, 34, 5);
        sw_if.i_sw_req = 1'b1;
        cyc();
        cyc();
        rst = 1'b1;
        sw_if.i_sw_req = 1'b0;
        cyc();
        chk_time("rst_wait_time", 0, 0, 0, 0);
        chk("rst_wait_flags", {sw_if.o_sw_ack, busy}, 0);
        rst = 1'b0;

        // Reset in the load cycle aborts the load and suppresses ack
        sw_if.i_sw_req = 1'b1;
        cyc();
        rst = 1'b1;
        sw_if.i_sw_req = 1'b0;
        cyc();
        chk("rst_load_ack", sw_if.o_sw_ack, 0);
        chk_time("rst_load_time", 0, 0, 0, 0);
        rst = 1'b0;
        cyc();
        chk("rst_load_ack2", sw_if.o_sw_ack, 0);

        // Buttons
        load_release(10, 59, 30);
        repeat (20) cyc();
        chk_time("adj_pre", 10, 59, 30, 5);
        adjm = 1'b1;
        cyc();
        adjm = 1'b0;
        chk_time("adj_min_wrap", 10, 0, 0, 0);
        adjm = 1'b1; adjh = 1'b1;
        cyc();
        adjm = 1'b0; adjh = 1'b0;
        chk_time("adj_both", 11, 1, 0, 0);
        set_sw(5, 5, 5);
        sw_if.i_sw_req = 1'b1;
        adjh = 1'b1;
        cyc();
        adjh = 1'b0;
        chk_time("adj_blocked", 11, 1, 0, 0);
        cyc();
        sw_if.i_sw_req = 1'b0;
        cyc();

        // Alarm fires once on a counted match
        amin = 8'd30; ahour = 8'd7; aen = 1'b1;
        load_release(7, 29, 59);
        nal = 0;
        repeat (40) begin
            cyc();
            if (alarm) begin
                nal++;
                chk_time("alarm_time", 7, 30, 0, 0);
            end
        end
        chk("alarm_count", nal, 1);

        // Loading the matching time directly does not fire
        nal = 0;
        set_sw(7, 30, 0);
        sw_if.i_sw_req = 1'b1;
        repeat (2) begin cyc(); if (alarm) nal++; end
        sw_if.i_sw_req = 1'b0;
        repeat (3) begin cyc(); if (alarm) nal++; end
        chk("alarm_on_load", nal, 0);
        aen = 1'b0;

        // Pause mid-count and resume with the remaining prescaler cycles
        load_release(3, 4, 5);
        repeat (6) cyc();
        run = 1'b0;
        ticks = 0;
        repeat (20) begin cyc(); if (tick) ticks++; end
        chk("pause_ticks", ticks, 0);
        chk_time("pause_time", 3, 4, 5, 1);
        run = 1'b1;
        cyc();
        chk("resume_tick1", tick, 0);
        cyc();
        chk("resume_tick2", tick, 1);
        chk_time("resume_time", 3, 4, 5, 2);

        // Random stimulus against the model
        for (int n = 0; n < 4000; n++) begin
            int h, m, s;
            rst  = ($urandom_range(0, 299) == 0);
            run  = ($urandom_range(0, 9) != 0);
            adjm = ($urandom_range(0, 39) == 0);
            adjh = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 99) == 0) aen = ~aen;
            if (sw_if.i_sw_req) begin
                if ($urandom_range(0, 2) == 0) sw_if.i_sw_req = 1'b0;
            end else if ($urandom_range(0, 59) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    h = $urandom_range(0, 255); m = $urandom_range(0, 255); s = $urandom_range(0, 255);
                end else begin
                    h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = 59;
                    ahour = 8'(h);
                    amin  = 8'((m + 1) % 60);
                    if (m == 59) ahour = 8'((h + 1) % 24);
                end
                set_sw(h, m, s);
                sw_if.i_sw_req = 1'b1;
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_time_ctrl.md
Name: rtc_time_ctrl

Overview:
Single-clock time-of-day controller for the AXI RTC clock IP. It owns the tenth-of-second/sec/min/hour registers and sequences them from one prescaled tick, with no derived clocks. It arbitrates time writes between the AXI software interface (level request/ack handshake) and front-panel adjust buttons, and raises a one-cycle alarm pulse on a programmed hour:minute match. Its outputs drive the display formatter and the AXI read registers.

Parameters:
TICK_DIV, 10_000_000, i_clk cycles per 0.1 s tick; must be >= 2. The bench uses 4.

Ports:
i_clk  in  1  system clock; all logic on its rising edge
i_reset  in  1  synchronous, active-high reset
i_run  in  1  1 = counting enabled; 0 = prescaler and time hold
i_sw_req  in  1  software set request (level)
i_sw_sec  in  8  seconds to load
i_sw_min  in  8  minutes to load
i_sw_hour  in  8  hours to load
o_sw_ack  out  1  one-cycle pulse: load performed
i_adj_min  in  1  button pulse: minute +1
i_adj_hour  in  1  button pulse: hour +1
i_alarm_en  in  1  alarm enable
i_alarm_min  in  8  alarm minute
i_alarm_hour  in  8  alarm hour
o_msec  out  8  tenths of a second, 0..9
o_sec  out  8  seconds, 0..59
o_min  out  8  minutes, 0..59
o_hour  out  8  hours, 0..23
o_tick  out  1  one-cycle pulse at each counting increment
o_alarm  out  1  one-cycle alarm pulse
o_busy  out  1  1 when FSM is not in RUN

Behaviour:
- Reset (i_reset=1 at an edge): all time outputs 0, prescaler 0, FSM=RUN, o_sw_ack/o_tick/o_alarm/o_busy 0.
- Reset has priority over every other input. Reset in mid-handshake aborts the load; o_sw_ack is not asserted.
- FSM states: RUN, LOAD, WAIT_REL.
- Prescaler counts only in RUN with i_run=1. At TICK_DIV-1 it wraps to 0 and an increment is applied at that same edge. o_tick is registered, so it is high during the following cycle.
- Increment carry chain (all fields in one edge):
  - msec 9 -> 0 carries to sec.
  - sec 59 -> 0 carries to min.
  - min 59 -> 0 carries to hour.
  - hour 23 -> 0.
  - 23:59:59.9 -> 00:00:00.0.
- i_run=0: prescaler and time hold; no o_tick.
- Software set:
  - In RUN, sampling i_sw_req=1 moves the FSM to LOAD. A tick due at that edge is still applied.
  - At the LOAD edge: sec/min/hour <= inputs, msec <= 0, prescaler <= 0, o_sw_ack=1 for one cycle, FSM -> WAIT_REL.
  - Out-of-range inputs saturate: sec/min > 59 load 59; hour > 23 load 23.
  - WAIT_REL -> RUN on the first edge that samples i_sw_req=0.
  - Latency: req sampled at edge N -> fields updated and o_sw_ack high after edge N+1.
  - Counting is suspended in LOAD and WAIT_REL.
- Button adjust (accepted only in RUN with i_sw_req=0; otherwise dropped):
  - i_adj_min: min+1, wraps 59 -> 0 with no carry to hour.
  - i_adj_hour: hour+1, wraps 23 -> 0.
  - Any accepted adjust clears sec, msec and the prescaler.
  - Both pulses in the same cycle: both applied.
  - Adjust coinciding with a tick: adjust wins and the tick increment is dropped.
  - Software request always has priority over buttons.
- Alarm: o_alarm=1 for one cycle, in the cycle after a tick increment produces hour==i_alarm_hour, min==i_alarm_min, sec==0, msec==0, with i_alarm_en=1.
  - A load or adjust landing on the matching time does not fire the alarm.
  - Alarm values > 59 (min) or > 23 (hour) never match.
- o_busy = (FSM != RUN), registered.

Test Plan:
- Reset, i_run=1, TICK_DIV=4, run 40 cycles -> o_msec reaches 9 then 0 with o_sec=1; exactly 10 o_tick pulses.
- Load 23:59:59 via sw_req, then let 10 ticks elapse -> fields read 00:00:00.0; o_sw_ack a single pulse two edges after req rises; o_busy high until req drops.
- sw_req with sec=75, hour=30 -> loads 59 and 23. Assert i_reset while in WAIT_REL -> all zeros, no ack, o_busy=0.
- At 10:59:30.5: pulse i_adj_min -> 10:00:00.0. Pulse both adjusts together -> 11:01:00.0. Pulse i_adj_hour while sw_req is high -> ignored.
- Alarm 07:30 enabled; load 07:29:59, run 10 ticks -> one o_alarm pulse at 07:30:00.0. Load 07:30:00 directly -> no o_alarm.
- i_run=0 for 20 cycles mid-count -> time and prescaler frozen. Resume -> next tick arrives after the remaining prescaler cycles.
